wb_trace_buffer: RTL and testbench

Captures every architectural register write leaving the pipeline's writeback stage into a small FIFO with a cycle stamp, so a debug consumer (UART dumper, display scanner, or testbench) can drain the write history at its own pace. It sits directly downstream of the CPU top and taps its writeback outputs (`WB_RegWrite`, `WB_WriteAddr`, `WB_WriteData`). It never back-pressures the CPU: when full, new writes are dropped and counted.

---
 rtl/wb_trace_buffer.sv | 98 +++++++++
 tb/tb_wb_trace_buffer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_trace_buffer.sv
// Writeback trace FIFO: records {cycle stamp, dest reg, data} for every captured
// register write and drains them show-ahead at the consumer's pace.
module wb_trace_buffer #(
  parameter int DEPTH   = 16,
  parameter int STAMP_W = 16,
  parameter bit DROP_R0 = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb_regwrite,
  input  logic [4:0]                 wb_waddr,
  input  logic [31:0]                wb_wdata,
  input  logic                       clear,
  output logic                       trace_valid,
  input  logic                       trace_ready,
  output logic [STAMP_W+36:0]        trace_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [7:0]                 drop_count
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [STAMP_W+36:0] entry_t;
  typedef logic [AW:0]         ptr_t;

  localparam ptr_t                 PTR_ONE   = ptr_t'(1);
  localparam logic [STAMP_W-1:0]   STAMP_ONE = {{(STAMP_W-1){1'b0}}, 1'b1};

  entry_t             mem_q [DEPTH];
  ptr_t               wr_ptr_q, wr_ptr_d;
  ptr_t               rd_ptr_q, rd_ptr_d;
  logic [STAMP_W-1:0] stamp_q, stamp_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         drop_count_q, drop_count_d;

  logic full, empty, cap, pop, push;

  // Same index with differing MSB means the writer has lapped the reader once.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign cap  = wb_regwrite && !(DROP_R0 && (wb_waddr == 5'd0));
  assign pop  = !empty && trace_ready;
  assign push = cap && (!full || pop);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    stamp_d      = stamp_q + STAMP_ONE;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    if (clear) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      stamp_d      = '0;
      overflow_d   = 1'b0;
      drop_count_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (cap && full && !pop) begin
        overflow_d = 1'b1;
        if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      stamp_q      <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      stamp_q      <= stamp_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  // NOTE: the storage array has no reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q[AW-1:0]] <= {stamp_q, wb_waddr, wb_wdata};
  end

  assign count       = wr_ptr_q - rd_ptr_q;
  assign trace_valid = !empty;
  assign trace_data  = mem_q[rd_ptr_q[AW-1:0]];
  assign overflow    = overflow_q;
  assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Self-checking bench for wb_trace_buffer: directed vector table plus hand-written
// multi-cycle sequences, with a queue scoreboard and a STAMP_W=4 twin instance.
module tb_wb_trace_buffer;

  logic        clk, rst;
  logic        regwrite, clear, ready;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  logic        valid, ovf;
  logic [52:0] data;
  logic [4:0]  cnt;
  logic [7:0]  drop;

  logic        valid4, ovf4;
  logic [40:0] data4;
  logic [4:0]  cnt4;
  logic [7:0]  drop4;

  int checks = 0;
  int errors = 0;

  logic [52:0]  sb[$];
  logic [15:0]  stamp_m;
  logic         ovf_m;
  logic [7:0]   drop_m;

  wb_trace_buffer #(.DEPTH(16), .STAMP_W(16), .DROP_R0(1'b1)) u_dut (
    .clk(clk), .rst(rst), .wb_regwrite(regwrite), .wb_waddr(waddr), .wb_wdata(wdata),
    .clear(clear), .trace_valid(valid), .trace_ready(ready), .trace_data(data),
    .count(cnt), .overflow(ovf), .drop_count(drop)
  );

  wb_trace_buffer #(.DEPTH(16), .STAMP_W(4), .DROP_R0(1'b1)) u_dut4 (
    .clk(clk), .rst(rst), .wb_regwrite(regwrite), .wb_waddr(waddr), .wb_wdata(wdata),
    .clear(clear), .trace_valid(valid4), .trace_ready(ready), .trace_data(data4),
    .count(cnt4), .overflow(ovf4), .drop_count(drop4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Apply current inputs at the next rising edge and advance the scoreboard.
  task automatic cycle();
    bit cap, pop;
    cap = regwrite && (waddr != 5'd0);
    pop = (sb.size() != 0) && ready;
    @(posedge clk);
    if (clear) begin
      sb.delete();
      ovf_m = 1'b0; drop_m = 8'd0; stamp_m = 16'd0;
    end else begin
      if (pop) void'(sb.pop_front());
      if (cap) begin
        if (sb.size() < 16) sb.push_back({stamp_m, waddr, wdata});
        else begin
          ovf_m = 1'b1;
          if (drop_m != 8'hFF) drop_m = drop_m + 8'd1;
        end
      end
      stamp_m = stamp_m + 16'd1;
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_count"}, cnt, sb.size());
    check({tag, "_valid"}, valid, sb.size() != 0);
    check({tag, "_overflow"}, ovf, ovf_m);
    check({tag, "_drop"}, drop, drop_m);
    check({tag, "_count4"}, cnt4, sb.size());
    if (sb.size() != 0) begin
      check({tag, "_data"}, data, sb[0]);
      check({tag, "_data4"}, data4, sb[0][40:0]);
    end
  endtask

  task automatic set_in(input logic w, input logic [4:0] a, input logic [31:0] d, input logic r);
    regwrite = w; waddr = a; wdata = d; ready = r;
  endtask

  task automatic do_clear();
    set_in(1'b0, 5'd0, 32'd0, 1'b0);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
  endtask

  typedef struct {
    logic        w;
    logic [4:0]  a;
    logic [31:0] d;
    logic        r;
    int          exp_cnt;
    logic        exp_v;
    logic [52:0] exp_data;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [52:0] e3, e4;
    int npop;
    e3 = {16'd3, 5'd5, 32'h1111_1111};
    e4 = {16'd4, 5'd6, 32'h2222_2222};
    // Row index equals the stamp of the edge it is applied at.
    vecs[0]  = '{1'b0, 5'd0, 32'h0,         1'b0, 0, 1'b0, '0};
    vecs[1]  = '{1'b0, 5'd0, 32'h0,         1'b0, 0, 1'b0, '0};
    vecs[2]  = '{1'b0, 5'd0, 32'h0,         1'b0, 0, 1'b0, '0};
    vecs[3]  = '{1'b1, 5'd5, 32'h1111_1111, 1'b0, 1, 1'b1, e3};
    vecs[4]  = '{1'b1, 5'd6, 32'h2222_2222, 1'b0, 2, 1'b1, e3};
    vecs[5]  = '{1'b0, 5'd0, 32'h0,         1'b0, 2, 1'b1, e3};
    vecs[6]  = '{1'b0, 5'd0, 32'h0,         1'b0, 2, 1'b1, e3};
    vecs[7]  = '{1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 2, 1'b1, e3};
    vecs[8]  = '{1'b0, 5'd0, 32'h0,         1'b1, 1, 1'b1, e4};
    vecs[9]  = '{1'b0, 5'd0, 32'h0,         1'b1, 0, 1'b0, '0};
    vecs[10] = '{1'b0, 5'd0, 32'h0,         1'b1, 0, 1'b0, '0};

    rst = 1'b0; clear = 1'b0;
    set_in(1'b0, 5'd0, 32'd0, 1'b0);
    sb.delete(); stamp_m = 16'd0; ovf_m = 1'b0; drop_m = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", valid, 1'b0);
    check("reset_count", cnt, 5'd0);
    check("reset_overflow", ovf, 1'b0);
    check("reset_drop", drop, 8'd0);
    rst = 1'b1;

    // Basic capture from the vector table
    for (int i = 0; i < 11; i++) begin
      set_in(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].r);
      cycle();
      check($sformatf("vec%0d_count", i), cnt, vecs[i].exp_cnt);
      check($sformatf("vec%0d_valid", i), valid, vecs[i].exp_v);
      if (vecs[i].exp_v) check($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
    end
    check("basic_overflow", ovf, 1'b0);

    // Fill and overflow
    do_clear();
    for (int i = 0; i < 20; i++) begin
      set_in(1'b1, 5'((i % 31) + 1), 32'hA000_0000 + i, 1'b0);
      cycle();
      check_model("fill");
    end
    check("fill_count16", cnt, 5'd16);
    check("fill_overflow", ovf, 1'b1);
    check("fill_drop4", drop, 8'd4);
    for (int i = 0; i < 16; i++) begin
      set_in(1'b0, 5'd0, 32'd0, 1'b1);
      cycle();
      check_model("drain");
    end
    check("drain_empty", valid, 1'b0);

    // Drop counter saturation
    do_clear();
    for (int i = 0; i < 276; i++) begin
      set_in(1'b1, 5'd2, 32'h5A5A_0000 + i, 1'b0);
      cycle();
    end
    check_model("sat");
    check("sat_drop255", drop, 8'hFF);

    // Simultaneous push and pop at full; STAMP_W=4 wrap on the 17th entry
    do_clear();
    npop = 0;
    for (int i = 0; i < 16; i++) begin
      set_in(1'b1, 5'd7, 32'hB000_0000 + i, 1'b0);
      cycle();
    end
    check("pp_full", cnt, 5'd16);
    for (int i = 0; i < 26; i++) begin
      if (i < 10) set_in(1'b1, 5'd8, 32'hC000_0000 + i, 1'b1);
      else        set_in(1'b0, 5'd0, 32'd0, 1'b1);
      if (npop == 16) check("wrap4_stamp17", data4[40:37], 4'd0);
      npop++;
      cycle();
      check_model("pp");
      if (i < 10) begin
        check("pp_count16", cnt, 5'd16);
        check("pp_drop0", drop, 8'd0);
      end
    end
    check("pp_empty", valid, 1'b0);

    // Streaming with random ready
    do_clear();
    for (int i = 0; i < 100; i++) begin
      set_in(1'b1, 5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)));
      cycle();
      check_model("stream");
      check("stream_count_max", cnt <= 5'd16, 1'b1);
    end

    // Clear priority
    do_clear();
    for (int i = 0; i < 17; i++) begin
      set_in(1'b1, 5'd4, 32'hD000_0000 + i, 1'b0);
      cycle();
    end
    for (int i = 0; i < 11; i++) begin
      set_in(1'b0, 5'd0, 32'd0, 1'b1);
      cycle();
    end
    check("clr_pre_count5", cnt, 5'd5);
    check("clr_pre_overflow", ovf, 1'b1);
    set_in(1'b1, 5'd9, 32'h9999_9999, 1'b1);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    check("clr_count", cnt, 5'd0);
    check("clr_valid", valid, 1'b0);
    check("clr_overflow", ovf, 1'b0);
    check("clr_drop", drop, 8'd0);
    set_in(1'b1, 5'd1, 32'hCAFE_0001, 1'b0);
    cycle();
    check("clr_next_count", cnt, 5'd1);
    check("clr_next_stamp0", data, {16'd0, 5'd1, 32'hCAFE_0001});

    // Asynchronous reset mid-operation
    do_clear();
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, 5'd10, 32'hE000_0000 + i, 1'b0);
      cycle();
    end
    check("ar_pre_count8", cnt, 5'd8);
    #2;
    rst = 1'b0;
    #1;
    check("ar_valid", valid, 1'b0);
    check("ar_count", cnt, 5'd0);
    check("ar_count4", cnt4, 5'd0);
    sb.delete(); stamp_m = 16'd0; ovf_m = 1'b0; drop_m = 8'd0;
    set_in(1'b1, 5'd3, 32'h0BAD_F00D, 1'b0);
    #2;
    rst = 1'b1;
    cycle();
    check("ar_post_count", cnt, 5'd1);
    check("ar_post_stamp0", data, {16'd0, 5'd3, 32'h0BAD_F00D});
    check_model("ar_post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
